// File: rtl/clint_timer.sv
// Machine timer / software-interrupt unit: 64-bit mtime with prescaler, mtimecmp compare, msip.
// Optional macro CLINT_TIMER_HI_LATCH_EN adds a shadow of mtime[63:32] for tear-free lo-then-hi reads.
module clint_timer #(
    parameter int PRESCALE_WIDTH = 8,
    parameter int OFFSET_WIDTH   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    io_sel,
    input  logic                    io_wen,
    input  logic [OFFSET_WIDTH-1:0] io_addr,
    input  logic [3:0]              io_mask,
    input  logic [31:0]             io_wdata,
    output logic [31:0]             io_rdata,
    output logic                    io_timer_irq,
    output logic                    io_soft_irq,
    output logic                    io_interrupt
);

    localparam int WORD_WIDTH = OFFSET_WIDTH - 2;
    localparam logic [WORD_WIDTH-1:0] W_MTIME_LO = WORD_WIDTH'(0);
    localparam logic [WORD_WIDTH-1:0] W_MTIME_HI = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] W_CMP_LO   = WORD_WIDTH'(2);
    localparam logic [WORD_WIDTH-1:0] W_CMP_HI   = WORD_WIDTH'(3);
    localparam logic [WORD_WIDTH-1:0] W_CTRL     = WORD_WIDTH'(4);
    localparam logic [WORD_WIDTH-1:0] W_MSIP     = WORD_WIDTH'(5);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

    logic [63:0]               mtime_r;
    logic [63:0]               mtimecmp_r;
    logic                      enable_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [PRESCALE_WIDTH-1:0] cnt_r;
    logic                      msip_r;
    logic                      timer_irq_r;
    logic                      interrupt_r;

    logic [WORD_WIDTH-1:0]     word_s;
    logic                      wr_s;
    logic                      tick_s;
    logic [31:0]               ctrl_cur_s;
    logic [31:0]               ctrl_merged_s;
    logic [31:0]               mtime_hi_merged_s;
    logic [63:0]               mtime_nxt_s;
    logic [63:0]               mtimecmp_nxt_s;
    logic [PRESCALE_WIDTH-1:0] cnt_nxt_s;
    logic                      msip_nxt_s;
    logic                      timer_irq_nxt_s;
    logic [31:0]               rdata_s;

    assign word_s            = io_addr[OFFSET_WIDTH-1:2];
    assign wr_s              = io_sel & io_wen;
    assign tick_s            = enable_r & (cnt_r == prescale_r);
    assign ctrl_cur_s        = {{(24-PRESCALE_WIDTH){1'b0}}, prescale_r, 7'b0, enable_r};
    assign ctrl_merged_s     = merge_bytes(ctrl_cur_s, io_wdata, io_mask);
    assign mtime_hi_merged_s = merge_bytes(mtime_r[63:32], io_wdata, io_mask);
    assign timer_irq_nxt_s   = (mtime_r >= mtimecmp_r);

    // Next-state for mtime, mtimecmp, prescale counter and msip; software writes beat the tick.
    always_comb begin
        mtime_nxt_s    = mtime_r;
        mtimecmp_nxt_s = mtimecmp_r;
        cnt_nxt_s      = cnt_r;
        msip_nxt_s     = msip_r;
        if (wr_s && (word_s == W_MTIME_LO)) begin
            mtime_nxt_s = {mtime_r[63:32], merge_bytes(mtime_r[31:0], io_wdata, io_mask)};
        end else if (wr_s && (word_s == W_MTIME_HI)) begin
            mtime_nxt_s = {mtime_hi_merged_s, mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
        if (wr_s && (word_s == W_CMP_LO)) begin
            mtimecmp_nxt_s = {mtimecmp_r[63:32], merge_bytes(mtimecmp_r[31:0], io_wdata, io_mask)};
        end else if (wr_s && (word_s == W_CMP_HI)) begin
            mtimecmp_nxt_s = {merge_bytes(mtimecmp_r[63:32], io_wdata, io_mask), mtimecmp_r[31:0]};
        end else begin
            mtimecmp_nxt_s = mtimecmp_r;
        end
        if (wr_s && (word_s == W_CTRL)) begin
            cnt_nxt_s = '0;
        end else if (enable_r) begin
            cnt_nxt_s = tick_s ? '0 : cnt_r + PRESCALE_WIDTH'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
        if (wr_s && (word_s == W_MSIP) && io_mask[0]) begin
            msip_nxt_s = io_wdata[0];
        end else begin
            msip_nxt_s = msip_r;
        end
    end

    // State and interrupt output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_r     <= 64'd0;
            mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
            enable_r    <= 1'b1;
            prescale_r  <= '0;
            cnt_r       <= '0;
            msip_r      <= 1'b0;
            timer_irq_r <= 1'b0;
            interrupt_r <= 1'b0;
        end else begin
            mtime_r     <= mtime_nxt_s;
            mtimecmp_r  <= mtimecmp_nxt_s;
            cnt_r       <= cnt_nxt_s;
            msip_r      <= msip_nxt_s;
            timer_irq_r <= timer_irq_nxt_s;
            interrupt_r <= timer_irq_nxt_s | msip_nxt_s;
            if (wr_s && (word_s == W_CTRL)) begin
                enable_r   <= ctrl_merged_s[0];
                prescale_r <= ctrl_merged_s[8 +: PRESCALE_WIDTH];
            end else begin
                enable_r   <= enable_r;
                prescale_r <= prescale_r;
            end
        end
    end

    logic [31:0] hi_read_s;

`ifdef CLINT_TIMER_HI_LATCH_EN
    logic [31:0] hi_shadow_r;

    // Shadow of the high word, captured by a low-word read or a high-word write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_shadow_r <= 32'd0;
        end else if (io_sel && !io_wen && (word_s == W_MTIME_LO)) begin
            hi_shadow_r <= mtime_r[63:32];
        end else if (wr_s && (word_s == W_MTIME_HI)) begin
            hi_shadow_r <= mtime_hi_merged_s;
        end else begin
            hi_shadow_r <= hi_shadow_r;
        end
    end

    assign hi_read_s = hi_shadow_r;
`else
    assign hi_read_s = mtime_r[63:32];
`endif

    // Combinational read mux over the current register state.
    always_comb begin
        rdata_s = 32'd0;
        if (io_sel) begin
            case (word_s)
                W_MTIME_LO: rdata_s = mtime_r[31:0];
                W_MTIME_HI: rdata_s = hi_read_s;
                W_CMP_LO:   rdata_s = mtimecmp_r[31:0];
                W_CMP_HI:   rdata_s = mtimecmp_r[63:32];
                W_CTRL:     rdata_s = ctrl_cur_s;
                W_MSIP:     rdata_s = {31'd0, msip_r};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign io_rdata     = rdata_s;
    assign io_timer_irq = timer_irq_r;
    assign io_soft_irq  = msip_r;
    assign io_interrupt = interrupt_r;

endmodule

// File: tb/tb_clint_timer.sv
// Directed plus random bench for clint_timer against a behavioural register-file model.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_sel = 1'b0;
    logic        io_wen = 1'b0;
    logic [4:0]  io_addr = 5'd0;
    logic [3:0]  io_mask = 4'd0;
    logic [31:0] io_wdata = 32'd0;
    logic [31:0] io_rdata;
    logic        io_timer_irq;
    logic        io_soft_irq;
    logic        io_interrupt;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    logic [31:0] last_rd;

    // behavioural model state
    logic [63:0] m_time, m_cmp;
    logic        m_en, m_msip, m_irq;
    int          m_pre, m_cnt;
    logic [31:0] m_shadow;

    clint_timer #(.PRESCALE_WIDTH(8), .OFFSET_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .io_sel(io_sel), .io_wen(io_wen), .io_addr(io_addr),
        .io_mask(io_mask), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .io_timer_irq(io_timer_irq), .io_soft_irq(io_soft_irq), .io_interrupt(io_interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic sel, input logic [4:0] addr);
        if (!sel) return 32'd0;
        case (addr[4:2])
            3'd0: return m_time[31:0];
`ifdef CLINT_TIMER_HI_LATCH_EN
            3'd1: return m_shadow;
`else
            3'd1: return m_time[63:32];
`endif
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return (32'(m_pre) << 8) | {31'd0, m_en};
            3'd5: return {31'd0, m_msip};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic sel, input logic wen, input logic [4:0] addr,
                              input logic [3:0] mask, input logic [31:0] wdata);
        logic w;
        logic tick;
        logic [2:0] word;
        logic [31:0] ctrl;
        logic [63:0] old_time;
        if (rst) begin
            m_time = 64'd0; m_cmp = '1; m_en = 1'b1; m_pre = 0; m_cnt = 0;
            m_msip = 1'b0; m_irq = 1'b0; m_shadow = 32'd0;
            return;
        end
        w = sel && wen;
        word = addr[4:2];
        old_time = m_time;
        m_irq = (m_time >= m_cmp);
        tick = m_en && (m_cnt == m_pre);
        if (w && word == 3'd0)      m_time[31:0]  = mrg(old_time[31:0], wdata, mask);
        else if (w && word == 3'd1) m_time[63:32] = mrg(old_time[63:32], wdata, mask);
        else if (tick)              m_time = old_time + 64'd1;
        if (w && word == 3'd2) m_cmp[31:0]  = mrg(m_cmp[31:0], wdata, mask);
        if (w && word == 3'd3) m_cmp[63:32] = mrg(m_cmp[63:32], wdata, mask);
        if (w && word == 3'd4) begin
            ctrl = mrg((32'(m_pre) << 8) | {31'd0, m_en}, wdata, mask);
            m_en = ctrl[0];
            m_pre = int'(ctrl[15:8]);
            m_cnt = 0;
        end else if (m_en) begin
            m_cnt = tick ? 0 : m_cnt + 1;
        end
        if (w && word == 3'd5 && mask[0]) m_msip = wdata[0];
        if (sel && !wen && word == 3'd0) m_shadow = old_time[63:32];
        else if (w && word == 3'd1)      m_shadow = m_time[63:32];
    endtask

    task automatic cycle(input logic sel, input logic wen, input logic [4:0] addr,
                         input logic [3:0] mask, input logic [31:0] wdata);
        io_sel = sel; io_wen = wen; io_addr = addr; io_mask = mask; io_wdata = wdata;
        @(negedge clk);
        last_rd = io_rdata;
        if (chk_on) begin
            chk("rdata", io_rdata, model_read(sel, addr));
            chk("timer_irq", io_timer_irq, m_irq);
            chk("soft_irq", io_soft_irq, m_msip);
            chk("interrupt", io_interrupt, m_irq | m_msip);
        end
        @(posedge clk);
        model_step(sel, wen, addr, mask, wdata);
        #1;
    endtask

    task automatic idle();                                         cycle(1'b0, 1'b0, 5'd0, 4'd0, 32'd0); endtask
    task automatic rd(input logic [4:0] a);                        cycle(1'b1, 1'b0, a, 4'd0, 32'd0);    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m); cycle(1'b1, 1'b1, a, m, d); endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        idle();
        chk_on = 1'b1;
        idle();
        rst = 1'b0;
        chk("rst_timer_irq", io_timer_irq, 1'b0);
        chk("rst_interrupt", io_interrupt, 1'b0);

        repeat (10) idle();
        rd(5'h00); chk("idle10_lo", last_rd, 32'd10);
        rd(5'h04); chk("idle10_hi", last_rd, 32'd0);
        chk("idle_interrupt", io_interrupt, 1'b0);
        rd(5'h08); chk("rst_cmp_lo", last_rd, 32'hFFFF_FFFF);
        rd(5'h10); chk("rst_ctrl", last_rd, 32'h0000_0001);
        rd(5'h18); chk("unmapped_rd", last_rd, 32'd0);

        // carry from low to high word
        wr(5'h00, 32'hFFFF_FFFE, 4'hF);
        wr(5'h04, 32'h0, 4'hF);
        idle(); idle();
        rd(5'h00); chk("carry_lo", last_rd, 32'h0);
        rd(5'h04); chk("carry_hi", last_rd, 32'h1);

        // prescale 3: one increment per 4 cycles
        wr(5'h10, 32'h0000_0301, 4'hF);
        v = m_time[31:0];
        rd(5'h00);
        repeat (39) idle();
        rd(5'h00); chk("prescale3_40cyc", last_rd, v + 32'd10);
        wr(5'h10, 32'h0, 4'hF);
        v = m_time[31:0];
        repeat (20) idle();
        rd(5'h00); chk("disabled_frozen", last_rd, v);
        wr(5'h10, 32'h1, 4'hF);

        // compare interrupt
        wr(5'h04, 32'h0, 4'hF);
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h08, m_time[31:0] + 32'd5, 4'hF);
        repeat (4) idle();
        chk("irq_before", io_timer_irq, 1'b0);
        idle();
        chk("irq_rise", io_timer_irq, 1'b1);
        chk("irq_interrupt", io_interrupt, 1'b1);
        wr(5'h08, 32'hFFFF_FFFF, 4'hF);
        chk("irq_held_on_write", io_timer_irq, 1'b1);
        idle();
        chk("irq_clear", io_timer_irq, 1'b0);
        wr(5'h0C, 32'hFFFF_FFFF, 4'hF);
        chk("irq_stays_clear", io_timer_irq, 1'b0);

        // msip byte mask
        wr(5'h14, 32'h1, 4'b0010);
        chk("msip_masked", io_soft_irq, 1'b0);
        wr(5'h14, 32'h1, 4'b0001);
        chk("msip_set", io_soft_irq, 1'b1);
        chk("msip_interrupt", io_interrupt, 1'b1);
        wr(5'h14, 32'h0, 4'hF);
        wr(5'h18, 32'hFFFF_FFFF, 4'hF);
        rd(5'h18); chk("unmapped_wr", last_rd, 32'd0);

        // lo-then-hi read across a carry
        wr(5'h04, 32'h0, 4'hF);
        wr(5'h00, 32'hFFFF_FFFF, 4'hF);
        rd(5'h00); chk("latch_lo", last_rd, 32'hFFFF_FFFF);
        rd(5'h04);
`ifdef CLINT_TIMER_HI_LATCH_EN
        chk("latch_hi", last_rd, 32'h0);
`else
        chk("latch_hi", last_rd, 32'h1);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = ($urandom_range(1, 0) == 1) ? $urandom : ($urandom % 64);
            cycle(($urandom % 4) != 0, $urandom_range(1, 0) == 1, 5'($urandom),
                  4'($urandom), d);
        end

        // reset with concurrent write
        rst = 1'b1;
        wr(5'h00, 32'hDEAD_BEEF, 4'hF);
        rst = 1'b0;
        rd(5'h00); chk("midrst_lo", last_rd, 32'd0);
        rd(5'h0C); chk("midrst_cmp_hi", last_rd, 32'hFFFF_FFFF);
        chk("midrst_interrupt", io_interrupt, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped machine timer and software-interrupt unit on the core's data-memory side, directly downstream of the core's dmem port.
- Top-level glue decodes the core's dmem address/op into a select plus read/write strobes for this block.
- Block returns read data in the same cycle, because the core is single-cycle.
- Drives the core's interrupt input from a 64-bit mtime/mtimecmp compare, ORed with a software interrupt bit.

Parameters:
- PRESCALE_WIDTH, 8, width of prescale divisor field and internal prescale counter
- OFFSET_WIDTH, 5, byte-offset address bits decoded inside the block

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- io_sel  input  1  access targets this block this cycle
- io_wen  input  1  write strobe (qualified by io_sel)
- io_addr  input  OFFSET_WIDTH  byte offset; bits [1:0] ignored
- io_mask  input  4  byte-write mask, bit i enables wdata[8i+7:8i]
- io_wdata  input  32  write data
- io_rdata  output  32  combinational read data
- io_timer_irq  output  1  registered timer interrupt
- io_soft_irq  output  1  msip bit
- io_interrupt  output  1  io_timer_irq OR io_soft_irq; connects to the core's io_interrupt

Behaviour:
- Register map (word offsets):
  - 0x00 mtime[31:0]
  - 0x04 mtime[63:32]
  - 0x08 mtimecmp[31:0]
  - 0x0C mtimecmp[63:32]
  - 0x10 ctrl: bit0 enable; bits[8+PRESCALE_WIDTH-1:8] prescale
  - 0x14 msip: bit0
- Unmapped offsets: read 0; writes ignored.
- Reset values, applied on rising clk while rst=1:
  - mtime=0
  - mtimecmp=64'hFFFF_FFFF_FFFF_FFFF
  - enable=1, prescale=0, prescale counter=0
  - msip=0
  - io_timer_irq=0, io_soft_irq=0, io_interrupt=0
- io_rdata:
  - Combinational from current register state when io_sel=1; 0 when io_sel=0.
  - A same-cycle write does not affect the read value; new value is visible the next cycle.
  - Reads have no side effects, except as described under Optional Feature.
- Prescaler:
  - When enable=1, the counter increments each cycle.
  - When counter==prescale: tick=1 and the counter returns to 0.
  - prescale=0 means tick every cycle; prescale=N means tick every N+1 cycles.
  - When enable=0, the counter holds and no ticks occur.
  - A write to ctrl clears the counter.
- mtime:
  - On tick, mtime increments by 1 as full 64-bit unsigned; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - Carry from the low word into the high word occurs in the same cycle.
- Write priority: a software write to either mtime word in a cycle overrides that cycle's increment for the whole 64-bit value.
  - Written bytes take io_wdata.
  - Unwritten bytes keep their pre-increment value.
- Byte masks apply to all registers.
  - ctrl reserved bits are not stored.
  - msip stores bit0 only, when mask[0]=1.
- Timer interrupt:
  - io_timer_irq is registered: it equals (mtime >= mtimecmp, 64-bit unsigned) evaluated on the previous cycle's register values.
  - Level-sensitive; it clears one cycle after mtimecmp is raised above mtime or mtime is written below mtimecmp.
- Reset mid-operation: all state returns to reset values on that edge; any concurrent write is dropped.

Optional Feature:
- Macro: CLINT_TIMER_HI_LATCH_EN
- Defined:
  - A read of offset 0x00 (io_sel=1, io_wen=0) latches mtime[63:32] into a shadow register at the clock edge.
  - Reads of 0x04 return the shadow, not the live high word.
  - Shadow resets to 0.
  - A software write to mtime[63:32] also updates the shadow.
  - This gives a tear-free lo-then-hi 64-bit read sequence.
- Undefined: no shadow register; 0x04 reads return live mtime[63:32].

Test Plan:
- Reset, then idle 10 cycles with prescale=0 -> read 0x00 returns 10±1 (bench fixes exact phase); 0x04 returns 0; io_interrupt=0.
- Write mtime lo=0xFFFF_FFFE, hi=0, prescale=0 -> after 2 ticks lo=0x0000_0000 and hi=0x0000_0001.
- Write ctrl prescale=3 -> mtime increments exactly once every 4 cycles over 40 cycles (10 increments); write enable=0 -> mtime frozen.
- Write mtimecmp hi=0, then lo=mtime+5 -> io_timer_irq rises exactly 1 cycle after mtime reaches the compare value; writing mtimecmp lo=0xFFFF_FFFF, hi=0xFFFF_FFFF clears it on the next cycle.
- Masked write: 0x14 with wdata=1, mask=4'b0010 -> msip stays 0; repeat with mask=4'b0001 -> io_soft_irq=1 and io_interrupt=1 next cycle.
- With CLINT_TIMER_HI_LATCH_EN: preset mtime=0x0000_0000_FFFF_FFFF, read lo, wait until carry, read hi -> returns 0x0000_0000; without the macro, the same sequence returns 0x0000_0001.
